// File: rtl/xor_parity_arbiter.sv
// Shared XOR-reduction arbiter: round-robin grants one requester per frame, folds each
// accepted word's parity into an accumulator and returns the frame parity tagged by requester.
module xor_parity_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  output logic                res_parity,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           acc_q, acc_d;
  logic           res_valid_q, res_valid_d;
  logic           res_parity_q, res_parity_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic [IDW-1:0] sel;
  logic [IDW-1:0] idx;
  logic           found;
  logic [W-1:0]   word;
  logic           word_par;
  logic           beat;

  // (base + off) mod NREQ; both operands are already below NREQ
  function automatic logic [IDW-1:0] wrap_add(input int unsigned base, input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // First valid requester at or after the round-robin pointer
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = wrap_add(int'(rr_q), i);
      if (!found && req_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign word     = req_data[int'(grant_q)*W +: W];
  assign word_par = ^word;
  assign beat     = (state_q == StBusy) && req_valid[grant_q];

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    acc_d        = acc_q;
    res_valid_d  = res_valid_q;
    res_parity_d = res_parity_q;
    res_id_d     = res_id_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = sel;
          acc_d   = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (beat) begin
          acc_d = acc_q ^ word_par;
          if (req_last[grant_q]) begin
            res_parity_d = acc_q ^ word_par;
            res_id_d     = grant_q;
            res_valid_d  = 1'b1;
            state_d      = StDone;
          end
        end
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_d        = wrap_add(int'(grant_q), 1);
          acc_d       = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      grant_q      <= '0;
      acc_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      acc_q        <= acc_d;
      res_valid_q  <= res_valid_d;
      res_parity_q <= res_parity_d;
      res_id_q     <= res_id_d;
    end
  end

  // Ready is a pure decode of registered state, independent of req_valid
  always_comb begin
    req_ready = '0;
    if (state_q == StBusy) req_ready[grant_q] = 1'b1;
  end

  assign res_valid  = res_valid_q;
  assign res_parity = res_parity_q;
  assign res_id     = res_id_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_xor_parity_arbiter.sv
// Bench for xor_parity_arbiter: vector table, hand-written corner sequences and a randomized
// run checked against a queue-based frame model.
module tb_xor_parity_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0]  req_last = '0;
  logic [NREQ-1:0]  req_ready;
  logic             res_valid;
  logic             res_parity;
  logic [1:0]       res_id;
  logic             res_ready = 1'b0;
  logic             busy;

  int total = 0;
  int bad   = 0;

  xor_parity_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_parity (res_parity),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] data;
    logic [3:0]   last;
    logic         exp_par;
    logic [1:0]   exp_id;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_res_valid"}, 32'(res_valid), 0);
    chk({nm, "_res_parity"}, 32'(res_parity), 0);
    chk({nm, "_res_id"}, 32'(res_id), 0);
    chk({nm, "_req_ready"}, 32'(req_ready), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single-beat frame from IDLE with res_ready high; called at a negedge with DUT idle
  task automatic apply_vec(input vec_t v, input string nm);
    logic [3:0] oh;
    oh        = 4'b0001 << v.exp_id;
    req_valid = v.valid;
    req_data  = v.data;
    req_last  = v.last;
    res_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_grant"}, 32'(req_ready), 32'(oh));
    chk({nm, "_busy"}, 32'(busy), 1);
    chk({nm, "_early_valid"}, 32'(res_valid), 0);
    @(negedge clk);
    chk({nm, "_res_valid"}, 32'(res_valid), 1);
    chk({nm, "_res_parity"}, 32'(res_parity), 32'(v.exp_par));
    chk({nm, "_res_id"}, 32'(res_id), 32'(v.exp_id));
    chk({nm, "_ready_done"}, 32'(req_ready), 0);
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk({nm, "_idle"}, 32'(busy), 0);
    chk({nm, "_valid_clr"}, 32'(res_valid), 0);
  endtask

  vec_t vecs[7];

  // Random-phase model state
  logic [31:0] wq[NREQ][$];
  bit          lq[NREQ][$];
  bit          pq[NREQ][$];
  int          fcnt[NREQ];
  bit          started[NREQ];
  int          waitc[NREQ];

  initial begin
    int rr_exp[5];
    int rr_par[5];
    int n, c, last_c;
    int got, cyc, rr_m, maxwait, e;
    bit ep;
    logic [31:0] w;
    int k, len;
    bit p;

    vecs[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h0000_0007}, 4'b0001, 1'b1, 2'd0};
    vecs[1] = '{4'b0011, {32'h0, 32'h0, 32'h3, 32'h0}, 4'b0011, 1'b0, 2'd1};
    vecs[2] = '{4'b0011, {32'h0, 32'h0, 32'h0, 32'h1}, 4'b0011, 1'b1, 2'd0};
    vecs[3] = '{4'b1000, {32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0}, 4'b1000, 1'b1, 2'd3};
    vecs[4] = '{4'b1111, {32'h0, 32'h0, 32'h1, 32'h8000_0001}, 4'b1111, 1'b0, 2'd0};
    vecs[5] = '{4'b0100, {32'h0, 32'h1234_5678, 32'h0, 32'h0}, 4'b0100, 1'b1, 2'd2};
    vecs[6] = '{4'b0101, {32'h0, 32'h0, 32'h0, 32'h0000_000F}, 4'b0101, 1'b0, 2'd0};
    rr_exp = '{0, 1, 2, 3, 0};
    rr_par = '{1, 0, 1, 0, 1};

    do_reset();
    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Multi-word frame from requester 2 with a 3-cycle stall; pointer now at 1
    req_valid = 4'b0100;
    req_data  = {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    req_last  = 4'b0000;
    @(negedge clk);
    chk("stall_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'b0001;
    req_last  = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", 32'(req_ready), 32'b0100);
      chk("stall_no_res", 32'(res_valid), 0);
    end
    req_valid = 4'b0101;
    req_data  = {32'h0, 32'h0000_0001, 32'h0, 32'h0};
    @(negedge clk);
    chk("stall_res_valid", 32'(res_valid), 1);
    chk("stall_parity", 32'(res_parity), 1);
    chk("stall_id", 32'(res_id), 2);
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    chk("stall_idle", 32'(busy), 0);

    // Result backpressure; pointer now at 3
    res_ready = 1'b0;
    req_valid = 4'b0010;
    req_data  = {32'h0, 32'h0, 32'h1, 32'h0};
    req_last  = 4'b0010;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_parity", 32'(res_parity), 1);
      chk("bp_id", 32'(res_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    res_ready = 1'b1;
    req_valid = 4'b0001;
    req_data  = '0;
    req_last  = 4'b0001;
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_ready", 32'(req_ready), 0);
    chk("bp_idle_valid", 32'(res_valid), 0);
    @(negedge clk);
    chk("bp_regrant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("bp2_parity", 32'(res_parity), 0);
    chk("bp2_id", 32'(res_id), 0);
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);

    // Reset in the middle of a 4-beat frame from requester 1 after 2 beats
    req_valid = 4'b0010;
    req_data  = {32'h0, 32'h0, 32'h1, 32'h0};
    req_last  = 4'b0000;
    @(negedge clk);
    chk("rst_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_data = {32'h0, 32'h0, 32'h3, 32'h0};
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk_reset_outputs("midrst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_no_res", 32'(res_valid), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    apply_vec('{4'b0010, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0010, 1'b0, 2'd1}, "postrst");

    // Round-robin fairness with all requesters busy
    do_reset();
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = {32'h0, 32'h7, 32'h3, 32'h1};
    res_ready = 1'b1;
    n = 0;
    c = 0;
    last_c = 0;
    while (n < 5 && c < 40) begin
      @(negedge clk);
      c++;
      if (res_valid) begin
        chk("rr_id", 32'(res_id), 32'(rr_exp[n]));
        chk("rr_parity", 32'(res_parity), 32'(rr_par[n]));
        if (n > 0) chk("rr_gap", 32'(c - last_c), 3);
        last_c = c;
        n++;
        if (n == 5) begin
          req_valid = '0;
          req_last  = '0;
        end
      end
    end
    chk("rr_count", 32'(n), 5);

    // Randomized frames against the queue model
    do_reset();
    for (int f = 0; f < 100; f++) begin
      k   = $urandom_range(NREQ - 1);
      len = $urandom_range(8, 1);
      p   = 1'b0;
      for (int b = 0; b < len; b++) begin
        w = $urandom;
        p = p ^ (^w);
        wq[k].push_back(w);
        lq[k].push_back(b == len - 1);
      end
      pq[k].push_back(p);
      fcnt[k]++;
    end
    got = 0;
    cyc = 0;
    rr_m = 0;
    maxwait = 0;
    while (got < 100 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      for (int j = 0; j < NREQ; j++) begin
        if (wq[j].size() > 0) begin
          req_valid[j] = started[j] ? ($urandom_range(3) != 0) : 1'b1;
          req_data[j*W +: W] = wq[j][0];
          req_last[j] = lq[j][0];
        end else begin
          req_valid[j] = 1'b0;
          req_data[j*W +: W] = $urandom;
          req_last[j] = 1'($urandom_range(1));
        end
      end
      res_ready = 1'($urandom_range(1));
      #1;
      for (int j = 0; j < NREQ; j++) begin
        if (req_valid[j] && req_ready[j]) begin
          started[j] = !lq[j][0];
          void'(wq[j].pop_front());
          void'(lq[j].pop_front());
        end
      end
      if (res_valid && res_ready) begin
        e = -1;
        for (int i = 0; i < NREQ; i++)
          if (e < 0 && fcnt[(rr_m + i) % NREQ] > 0) e = (rr_m + i) % NREQ;
        if (e < 0) begin
          chk("rand_unexpected", 32'(res_valid), 0);
        end else begin
          ep = pq[e].pop_front();
          chk("rand_id", 32'(res_id), 32'(e));
          chk("rand_parity", 32'(res_parity), 32'(ep));
          fcnt[e]--;
          for (int j = 0; j < NREQ; j++) begin
            if (j != e && fcnt[j] > 0) begin
              waitc[j]++;
              if (waitc[j] > maxwait) maxwait = waitc[j];
            end
          end
          waitc[e] = 0;
          rr_m = (e + 1) % NREQ;
        end
        got++;
      end
    end
    req_valid = '0;
    req_last  = '0;
    chk("rand_count", 32'(got), 100);
    chk("rand_starve", 32'(maxwait <= NREQ), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
